mult_seq: RTL

Iterative 32x32 multiplier for the CPU54 datapath, the counterpart of the sequential divider; it executes MULT and MULTU and writes the 64-bit product to HI/LO. It uses one shift-add iteration per clock and a start/busy/done handshake. The control unit stalls the pipeline while `busy` is high and latches `hi`/`lo` into the HI/LO registers on `done`.

---
 rtl/mult_pkg.sv | 14 +
 rtl/mult_negate.sv | 12 +
 rtl/mult_seq.sv | 115 +++++++++++
 3 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types and constants for the sequential multiplier
package mult_pkg;

  localparam int MULT_W    = 32;
  localparam int MULT_ITER = 32;
  localparam int CNT_W     = 6;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } mult_state_t;

endpackage

// File: rtl/mult_negate.sv
// rtl/mult_negate.sv - conditional two's-complement negate
module mult_negate #(
  parameter int W = 32
) (
  input  logic [W-1:0] in,
  input  logic         en,
  output logic [W-1:0] out
);

  assign out = en ? (~in + W'(1)) : in;

endmodule

// File: rtl/mult_seq.sv
// rtl/mult_seq.sv - iterative shift-add MULT/MULTU unit, one iteration per clock
// Optional MULT_SEQ_EARLY_EXIT_EN: stop iterating once the remaining multiplier is zero.
module mult_seq
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  mult_state_t        state, next_state;
  logic [2*WIDTH-1:0] acc, mc, prod;
  logic [WIDTH-1:0]   mb, ma_mag, mb_mag;
  logic [CNT_W-1:0]   cnt;
  logic               neg, last_iter;

  mult_negate #(.W(WIDTH)) u_neg_a (
    .in (multiplicand),
    .en (sign & multiplicand[WIDTH-1]),
    .out(ma_mag)
  );

  mult_negate #(.W(WIDTH)) u_neg_b (
    .in (multiplier),
    .en (sign & multiplier[WIDTH-1]),
    .out(mb_mag)
  );

  mult_negate #(.W(2*WIDTH)) u_neg_p (
    .in (acc),
    .en (neg),
    .out(prod)
  );

`ifdef MULT_SEQ_EARLY_EXIT_EN
  // Post-shift multiplier empty means no partial products remain.
  assign last_iter = (cnt == LAST_CNT) || (mb[WIDTH-1:1] == '0);
`else
  assign last_iter = (cnt == LAST_CNT);
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
`ifdef MULT_SEQ_EARLY_EXIT_EN
          next_state = (mb_mag == '0) ? FIX : RUN;
`else
          next_state = RUN;
`endif
        end
      end
      RUN:     if (last_iter) next_state = FIX;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      acc  <= '0;
      mc   <= '0;
      mb   <= '0;
      cnt  <= '0;
      neg  <= 1'b0;
      hi   <= '0;
      lo   <= '0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc <= '0;
            mc  <= {{WIDTH{1'b0}}, ma_mag};
            mb  <= mb_mag;
            cnt <= '0;
            neg <= sign & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
          end
        end
        RUN: begin
          if (mb[0]) acc <= acc + mc;
          mc  <= mc << 1;
          mb  <= mb >> 1;
          cnt <= cnt + CNT_W'(1);
        end
        FIX: begin
          {hi, lo} <= prod;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
